// File: rtl/clock_bank.sv
// ---------------------------------------------------------------------------
// clock_bank
//
// Bank of NUM_CLOCKS timed-automaton clocks for the runtime-verification
// datapath. Each clock is a CLK_W-bit counter advanced either by its own
// prescaler tick or, when joined, by the carry of the clock below it. Each
// clock can wrap or saturate, keeps a sticky overflow flag, and can be
// cleared or loaded directly. One clock-constraint query per cycle compares
// a selected counter against an immediate.
//
// Ports:
//   clk, reset        : single clock domain, asynchronous active-high reset
//   en                : global time-advance enable
//   en_clk_reset      : qualifies the per-clock clear mask clk_reset
//   clk_reset         : per-clock synchronous clear mask
//   ld_en/ld_addr/ld_val : direct load of one counter
//   cfg_clk_joins     : bit i=1 -> clock i counts carries of clock i-1
//   cfg_saturate      : bit i=1 -> clock i saturates instead of wrapping
//   cfg_div_limits    : prescaler reload of clock i at [DIV_W*i +: DIV_W]
//   addr/op/imm       : query select, operation (<,==,>,>=), constant
//   counters          : clock i at [CLK_W*i +: CLK_W]
//   ovf               : sticky overflow flags
//   out_val           : query result (combinational from registered counters)
// ---------------------------------------------------------------------------
module clock_bank #(
   parameter int NUM_CLOCKS = 8,
   parameter int CLK_W      = 12,
   parameter int DIV_W      = 10,
   localparam int AW        = $clog2(NUM_CLOCKS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en,
   input  logic                        en_clk_reset,
   input  logic [NUM_CLOCKS-1:0]       clk_reset,
   input  logic                        ld_en,
   input  logic [AW-1:0]               ld_addr,
   input  logic [CLK_W-1:0]            ld_val,
   input  logic [NUM_CLOCKS-1:0]       cfg_clk_joins,
   input  logic [NUM_CLOCKS-1:0]       cfg_saturate,
   input  logic [NUM_CLOCKS*DIV_W-1:0] cfg_div_limits,
   input  logic [AW-1:0]               addr,
   input  logic [1:0]                  op,
   input  logic [CLK_W-1:0]            imm,
   output logic [NUM_CLOCKS*CLK_W-1:0] counters,
   output logic [NUM_CLOCKS-1:0]       ovf,
   output logic                        out_val
);

   logic [CLK_W-1:0]      cnt_q [NUM_CLOCKS];
   logic [DIV_W-1:0]      div_q [NUM_CLOCKS];
   logic [NUM_CLOCKS-1:0] ovf_q;

   logic [NUM_CLOCKS-1:0] tick;
   logic [NUM_CLOCKS-1:0] inc;
   logic [NUM_CLOCKS-1:0] carry;
   logic [NUM_CLOCKS-1:0] clr;
   logic [NUM_CLOCKS-1:0] ld;
   logic [NUM_CLOCKS-1:0] at_max;
   logic                  chain;
   logic [CLK_W-1:0]      sel_cnt;

   // Increment/carry chain. Evaluated bottom-up so a carry ripples through
   // any run of joined clocks in one cycle. Clock 0 never looks at a lower
   // neighbour, so the chain cannot loop.
   always_comb begin
      tick   = '0;
      inc    = '0;
      carry  = '0;
      clr    = '0;
      ld     = '0;
      at_max = '0;
      chain  = 1'b0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
         tick[i]   = (div_q[i] == '0);
         clr[i]    = en_clk_reset & clk_reset[i];
         ld[i]     = ld_en & (ld_addr == AW'(i));
         at_max[i] = &cnt_q[i];
         inc[i]    = (cfg_clk_joins[i] && (i != 0)) ? chain : tick[i];
         // A clear or load on this clock swallows the carry; a saturating
         // clock never carries.
         carry[i]  = en & inc[i] & at_max[i] & ~cfg_saturate[i] & ~clr[i] & ~ld[i];
         chain     = carry[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            cnt_q[i] <= '0;
            div_q[i] <= '0;
         end
         ovf_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (clr[i]) begin
               cnt_q[i] <= '0;
               div_q[i] <= '0;
               ovf_q[i] <= 1'b0;
            end else if (ld[i]) begin
               // Divider and overflow are left untouched by a load.
               cnt_q[i] <= ld_val;
            end else if (en) begin
               // The divider runs even when the clock is joined. A new limit
               // only matters at the next reload.
               div_q[i] <= tick[i] ? cfg_div_limits[DIV_W*i +: DIV_W]
                                   : div_q[i] - 1'b1;
               if (inc[i]) begin
                  if (at_max[i]) begin
                     ovf_q[i] <= 1'b1;
                     if (!cfg_saturate[i]) begin
                        cnt_q[i] <= '0;
                     end
                  end else begin
                     cnt_q[i] <= cnt_q[i] + 1'b1;
                  end
               end
            end
         end
      end
   end

   // Query mux: an out-of-range address (non-power-of-two bank) reads 0.
   always_comb begin
      sel_cnt = '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
         if (addr == AW'(i)) begin
            sel_cnt = cnt_q[i];
         end
      end
   end

   always_comb begin
      case (op)
         2'b00:   out_val = (sel_cnt <  imm);
         2'b01:   out_val = (sel_cnt == imm);
         2'b10:   out_val = (sel_cnt >  imm);
         default: out_val = (sel_cnt >= imm);
      endcase
   end

   genvar g;
   generate
      for (g = 0; g < NUM_CLOCKS; g++) begin : g_out
         assign counters[CLK_W*g +: CLK_W] = cnt_q[g];
      end
   endgenerate

   assign ovf = ovf_q;

endmodule

// File: tb/tb_clock_bank.sv
// ---------------------------------------------------------------------------
// tb_clock_bank
//
// Self-checking bench for clock_bank. A behavioural model (integer arrays,
// plain arithmetic) predicts counters, overflow flags and the query result
// each cycle; directed scenarios add fixed expected values.
// ---------------------------------------------------------------------------
module tb_clock_bank;

   localparam int N     = 8;
   localparam int CW    = 12;
   localparam int DW    = 10;
   localparam int AW    = $clog2(N);
   localparam int TW    = N*CW;
   localparam int MAXC  = (1 << CW) - 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic              en;
   logic              en_clk_reset;
   logic [N-1:0]      clk_reset;
   logic              ld_en;
   logic [AW-1:0]     ld_addr;
   logic [CW-1:0]     ld_val;
   logic [N-1:0]      cfg_clk_joins;
   logic [N-1:0]      cfg_saturate;
   logic [N*DW-1:0]   cfg_div_limits;
   logic [AW-1:0]     addr;
   logic [1:0]        op;
   logic [CW-1:0]     imm;
   logic [TW-1:0]     counters;
   logic [N-1:0]      ovf;
   logic              out_val;

   clock_bank #(.NUM_CLOCKS(N), .CLK_W(CW), .DIV_W(DW)) dut (
      .clk(clk), .reset(reset), .en(en), .en_clk_reset(en_clk_reset),
      .clk_reset(clk_reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_val(ld_val),
      .cfg_clk_joins(cfg_clk_joins), .cfg_saturate(cfg_saturate),
      .cfg_div_limits(cfg_div_limits), .addr(addr), .op(op), .imm(imm),
      .counters(counters), .ovf(ovf), .out_val(out_val)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [TW-1:0] exp_q[$];

   task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int mcnt[N];
   int mdiv[N];
   bit movf[N];

   function automatic void model_zero();
      for (int i = 0; i < N; i++) begin
         mcnt[i] = 0; mdiv[i] = 0; movf[i] = 0;
      end
   endfunction

   // One edge of time: a clock counts when its prescaler reaches zero, or,
   // if joined, when the clock below it rolled over on this same edge.
   function automatic void model_step();
      bit rolled = 0;
      for (int i = 0; i < N; i++) begin
         int  lim   = int'(cfg_div_limits[DW*i +: DW]);
         bit  tk    = (mdiv[i] == 0);
         bit  bump  = (i > 0 && cfg_clk_joins[i]) ? rolled : tk;
         bit  rnow  = 0;
         if (en_clk_reset && clk_reset[i]) begin
            mcnt[i] = 0; mdiv[i] = 0; movf[i] = 0;
         end else if (ld_en && int'(ld_addr) == i) begin
            mcnt[i] = int'(ld_val);
         end else if (en) begin
            mdiv[i] = tk ? lim : mdiv[i] - 1;
            if (bump) begin
               if (mcnt[i] == MAXC) begin
                  movf[i] = 1;
                  if (!cfg_saturate[i]) begin
                     mcnt[i] = 0;
                     rnow = 1;
                  end
               end else begin
                  mcnt[i] = mcnt[i] + 1;
               end
            end
         end
         rolled = rnow;
      end
   endfunction

   function automatic logic [TW-1:0] model_counters();
      logic [TW-1:0] v = '0;
      for (int i = 0; i < N; i++) v[CW*i +: CW] = CW'(mcnt[i]);
      return v;
   endfunction

   function automatic logic [N-1:0] model_ovf();
      logic [N-1:0] v = '0;
      for (int i = 0; i < N; i++) v[i] = movf[i];
      return v;
   endfunction

   function automatic logic model_query();
      int c = mcnt[addr];
      int k = int'(imm);
      case (op)
         2'b00:   return c <  k;
         2'b01:   return c == k;
         2'b10:   return c >  k;
         default: return c >= k;
      endcase
   endfunction

   function automatic logic [CW-1:0] dut_cnt(input int i);
      return counters[CW*i +: CW];
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      en = 0; en_clk_reset = 0; clk_reset = '0;
      ld_en = 0; ld_addr = '0; ld_val = '0;
   endtask

   task automatic set_limits(input int l0, input int others);
      for (int i = 0; i < N; i++)
         cfg_div_limits[DW*i +: DW] = DW'((i == 0) ? l0 : others);
   endtask

   // Apply current inputs for one edge, predict, then compare.
   task automatic step(input string tag);
      model_step();
      exp_q.push_back(model_counters());
      @(posedge clk);
      #1;
      check({tag, ".counters"}, counters, exp_q.pop_front());
      check({tag, ".ovf"}, TW'(ovf), TW'(model_ovf()));
      check({tag, ".out_val"}, TW'(out_val), TW'(model_query()));
   endtask

   task automatic clear_all();
      drive_idle();
      en_clk_reset = 1; clk_reset = '1;
      step("clear");
      drive_idle();
   endtask

   task automatic load(input int a, input int v);
      ld_en = 1; ld_addr = AW'(a); ld_val = CW'(v);
      step("load");
      ld_en = 0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      reset = 1;
      drive_idle();
      cfg_clk_joins = '0; cfg_saturate = '0; cfg_div_limits = '0;
      addr = '0; op = 2'b00; imm = 12'd5;
      model_zero();
      repeat (3) @(posedge clk);
      #1;
      check("reset.counters", counters, '0);
      check("reset.ovf", TW'(ovf), '0);
      check("reset.lt_imm5", TW'(out_val), TW'(1));
      imm = 12'd0; #1;
      check("reset.lt_imm0", TW'(out_val), TW'(0));
      reset = 0;

      // Divider: limit 2 -> counts on cycles 1, 4, 7
      set_limits(2, 0);
      en = 1;
      for (int c = 1; c <= 7; c++) begin
         step("div");
         if (c == 1) check("div.c1", TW'(dut_cnt(0)), TW'(1));
         if (c == 4) check("div.c4", TW'(dut_cnt(0)), TW'(2));
         if (c == 7) check("div.c7", TW'(dut_cnt(0)), TW'(3));
      end
      clear_all();

      // Chain: clock 0 ticks every cycle, clock 1 joined
      set_limits(0, 5);
      cfg_clk_joins = 8'b0000_0010;
      en = 1;
      repeat (4096) step("chain");
      check("chain.cnt0", TW'(dut_cnt(0)), TW'(0));
      check("chain.cnt1", TW'(dut_cnt(1)), TW'(1));
      check("chain.ovf0", TW'(ovf[0]), TW'(1));
      check("chain.ovf1", TW'(ovf[1]), TW'(0));
      clear_all();

      // Saturate: clock 0 saturates, clock 1 joined stays frozen
      cfg_saturate = 8'b0000_0001;
      load(0, 4094);
      en = 1;
      repeat (3) step("sat");
      check("sat.cnt0", TW'(dut_cnt(0)), TW'(4095));
      check("sat.ovf0", TW'(ovf[0]), TW'(1));
      check("sat.cnt1", TW'(dut_cnt(1)), TW'(0));
      cfg_saturate = '0; cfg_clk_joins = '0;
      clear_all();

      // Priority: clear beats load, load alone applies, en=0 holds
      ld_en = 1; ld_addr = 3'd2; ld_val = 12'd5;
      en_clk_reset = 1; clk_reset = 8'h04;
      step("prio.both");
      check("prio.clr_wins", TW'(dut_cnt(2)), TW'(0));
      drive_idle();
      load(2, 5);
      check("prio.load", TW'(dut_cnt(2)), TW'(5));
      step("prio.hold");
      check("prio.hold", TW'(dut_cnt(2)), TW'(5));

      // Query against cnt_3 = 100
      load(3, 100);
      addr = 3'd3;
      op = 2'b00; imm = 12'd101; #1; check("q.lt", TW'(out_val), TW'(1));
      op = 2'b01; imm = 12'd100; #1; check("q.eq", TW'(out_val), TW'(1));
      op = 2'b10; imm = 12'd100; #1; check("q.gt", TW'(out_val), TW'(0));
      op = 2'b11; imm = 12'd100; #1; check("q.ge", TW'(out_val), TW'(1));

      // Randomized traffic checked against the model
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) begin
            cfg_clk_joins = N'($urandom);
            cfg_saturate  = N'($urandom);
            for (int i = 0; i < N; i++)
               cfg_div_limits[DW*i +: DW] = DW'($urandom_range(0, 3));
         end
         en           = ($urandom_range(0, 9) < 8);
         en_clk_reset = ($urandom_range(0, 49) == 0);
         clk_reset    = N'($urandom);
         ld_en        = ($urandom_range(0, 9) == 0);
         ld_addr      = AW'($urandom);
         ld_val       = ($urandom_range(0, 1) == 1) ? CW'($urandom_range(MAXC - 3, MAXC))
                                                    : CW'($urandom);
         addr         = AW'($urandom);
         op           = 2'($urandom);
         imm          = ($urandom_range(0, 1) == 1) ? CW'(mcnt[addr]) : CW'($urandom);
         step("rand");
      end

      // Reset mid-run
      drive_idle();
      load(0, 7);
      en = 1; cfg_clk_joins = '0; set_limits(3, 3);
      reset = 1;
      #1;
      check("midrst.counters", counters, '0);
      check("midrst.ovf", TW'(ovf), '0);
      @(posedge clk);
      #1;
      reset = 0;
      model_zero();
      step("post_rst");
      check("post_rst.tick", TW'(dut_cnt(0)), TW'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clock_bank.md
# clock_bank

Parametrised bank of `NUM_CLOCKS` timed-automaton clocks, each `CLK_W` bits wide. Every clock has its own prescaler, and each clock can optionally be chained to the carry of its lower neighbour. Each clock also has per-clock wrap/saturate mode, a sticky overflow flag and a direct load port. It evaluates one clock-constraint query per cycle against a selected clock. It replaces the fixed 8-clock, mixed 4/12-bit bank in the runtime-verification datapath.

## Interface
Parameters:
- `NUM_CLOCKS`, 8: number of clocks; ≥2. `AW = $clog2(NUM_CLOCKS)`.
- `CLK_W`, 12: width of every counter.
- `DIV_W`, 10: prescaler width per clock.

Ports:
- `clk`  in  1  clock. One clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  global time-advance enable.
- `en_clk_reset`  in  1  qualifies `clk_reset`.
- `clk_reset`  in  NUM_CLOCKS  per-clock synchronous clear mask.
- `ld_en`  in  1  load strobe.
- `ld_addr`  in  AW  clock to load.
- `ld_val`  in  CLK_W  load value.
- `cfg_clk_joins`  in  NUM_CLOCKS  bit i=1: clock i increments on the carry of clock i-1. Bit 0 is ignored.
- `cfg_saturate`  in  NUM_CLOCKS  bit i=1: clock i saturates at all-ones instead of wrapping.
- `cfg_div_limits`  in  NUM_CLOCKS*DIV_W  prescaler limit of clock i at `[DIV_W*i +: DIV_W]`.
- `addr`  in  AW  clock selected for the query.
- `op`  in  2  query operation: 00 `<`, 01 `==`, 10 `>`, 11 `>=`.
- `imm`  in  CLK_W  comparison constant (unsigned).
- `counters`  out  NUM_CLOCKS*CLK_W  clock i at `[CLK_W*i +: CLK_W]`.
- `ovf`  out  NUM_CLOCKS  sticky overflow flags.
- `out_val`  out  1  query result.

## Operation
Per clock i, with state `cnt_i` (CLK_W bits), `div_i` (DIV_W bits) and `ovf_i`:
- `tick_i = (div_i == 0)`.
- `inc_i = join_i ? carry_{i-1} : tick_i`. `join_0` is treated as 0, so the chain has no combinational loop.
- `carry_i = en & inc_i & (cnt_i == all-ones) & ~saturate_i & ~clr_i & ~ld_i`.
- `clr_i = en_clk_reset & clk_reset[i]`.
- `ld_i = ld_en & (ld_addr == i)`.

Per-clock update priority (highest first):
1. `clr_i`: `cnt_i`, `div_i` and `ovf_i` go to 0. This applies regardless of `en`.
2. `ld_i`: `cnt_i <= ld_val`. `div_i` and `ovf_i` are unchanged. This applies regardless of `en`.
3. `en`:
   - Divider: `div_i <= tick_i ? limit_i : div_i - 1`. With this rule, clock i's own prescaler has period `limit_i + 1` enabled cycles.
   - Counter, when `inc_i`:
     - If `cnt_i` is all-ones and `saturate_i=1`: hold, set `ovf_i`.
     - If `cnt_i` is all-ones and `saturate_i=0`: `cnt_i` goes to 0, set `ovf_i`.
     - Otherwise: `cnt_i + 1`.
   - Under `clr_i` or `ld_i`, the divider still follows the rules above (clr zeroes it; ld leaves it untouched).
4. `en=0`: counters and dividers hold.

Other rules:
- The divider runs even when the clock is joined; it is unused in that case.
- A saturating clock never generates a carry, so clocks joined above it freeze once it saturates.
- Changing `cfg_div_limits` takes effect at the next reload; the current `div_i` is not truncated.

Query:
- `out_val` is combinational from the registered `cnt_addr`, `op` and `imm`, using an unsigned compare.

## Timing
- All state resets to 0 asynchronously. After reset: `counters=0`, `ovf=0`, and `out_val` follows `op` against count 0 (`<` is true iff `imm>0`).
- Counter and flag updates are visible the cycle after the enabling edge.
- A carry ripples through any run of joined clocks within one cycle. Example: clocks 0 and 1 at all-ones with clock 1 joined roll over together on a single edge.
- The first enabled cycle after reset or `clr_i` always ticks, because `div_i=0`.
- Simultaneous events on the same clock:
  - `clr_i` with `ld_i`: the clear wins.
  - `ld_i` with an incoming carry: the load wins, the carry is lost and no ovf is set.
- `reset` asserted mid-chain overrides everything immediately.

## Test plan
- Divider: reset; `limit_0=2`, join off, `en=1` continuously. Expect `cnt_0=1` after cycle 1, 2 after cycle 4, 3 after cycle 7.
- Chain: `limit_0=0`, `join_1=1`, `en=1` for 4096 cycles. Expect `cnt_0=0`, `cnt_1=1`, `ovf_0=1`, `ovf_1=0`.
- Saturate: `saturate_0=1`, `join_1=1`; load `cnt_0=4094`; run 3 enabled cycles with `limit_0=0`. Expect `cnt_0=4095`, `ovf_0=1`, `cnt_1=0`.
- Priority: same cycle `ld_en` to clock 2 with `ld_val=5` and `en_clk_reset` with `clk_reset=0x04`. Expect `cnt_2=0`. Next cycle load alone: expect `cnt_2=5`. With `en=0`, expect `cnt_2` held at 5.
- Query: `cnt_3=100`; `op` 00 with `imm=101` → 1; 01 with 100 → 1; 10 with 100 → 0; 11 with 100 → 1.
- Reset mid-run: assert `reset` while counters are non-zero. Expect all `counters`/`ovf` 0 immediately, and counting resumes with a tick on the first enabled cycle after release.
